draw_scheduler: RTL

- Front-end controller for the circle engine. Accepts a queue of circle-draw commands and an optional full-screen clear.
- Launches one circle job at a time through the engine's start/done handshake.
- Owns the single VGA plot port, multiplexing it between its internal clear sweep and the circle engine.
- Sits between the top-level stimulus/command source and the VGA adapter.

---
 rtl/draw_scheduler.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/draw_scheduler.sv
// Circle-engine front end: command FIFO, one-at-a-time job launch, full-screen clear sweep and
// VGA plot-port mux. Define DRAW_SCHED_STATS_EN to add the circles_drawn counter output.
module draw_scheduler #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_colour,
  input  logic [7:0]                 cmd_cx,
  input  logic [6:0]                 cmd_cy,
  input  logic [7:0]                 cmd_radius,
  input  logic                       clear_req,
  input  logic [2:0]                 clear_colour,
  output logic                       circ_start,
  input  logic                       circ_done,
  output logic [2:0]                 circ_colour,
  output logic [7:0]                 circ_cx,
  output logic [6:0]                 circ_cy,
  output logic [7:0]                 circ_radius,
  input  logic [7:0]                 circ_vga_x,
  input  logic [6:0]                 circ_vga_y,
  input  logic [2:0]                 circ_vga_colour,
  input  logic                       circ_vga_plot,
  output logic [7:0]                 vga_x,
  output logic [6:0]                 vga_y,
  output logic [2:0]                 vga_colour,
  output logic                       vga_plot,
  output logic [$clog2(DEPTH):0]     fifo_count,
`ifdef DRAW_SCHED_STATS_EN
  output logic [15:0]                circles_drawn,
`endif
  output logic                       busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 26;
  localparam logic [7:0] XMax = 8'(SCREEN_W - 1);
  localparam logic [6:0] YMax = 7'(SCREEN_H - 1);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StWaitIdle} state_e;

  state_e          state_q, state_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            clear_pending_q, clear_pending_d;
  logic [7:0]      x_q, x_d;
  logic [6:0]      y_q, y_d;
  logic [2:0]      clr_colour_q;
  logic            circ_start_q, circ_start_d;
  logic [EW-1:0]   job_q;
  logic            push, launch, clear_start, done_accept;

  assign cmd_ready  = (count_q != (AW+1)'(DEPTH));
  assign push       = cmd_valid & cmd_ready;
  assign fifo_count = count_q;
  assign busy       = (state_q != StIdle) | (count_q != '0) | clear_pending_q;
  assign done_accept = (state_q == StRun) & circ_done;

  assign circ_start  = circ_start_q;
  assign circ_colour = job_q[25:23];
  assign circ_cx     = job_q[22:15];
  assign circ_cy     = job_q[14:8];
  assign circ_radius = job_q[7:0];

  // Next-state: a pending clear always wins over queued circles at IDLE.
  always_comb begin
    state_d      = state_q;
    launch       = 1'b0;
    clear_start  = 1'b0;
    circ_start_d = circ_start_q;
    x_d          = x_q;
    y_d          = y_q;
    case (state_q)
      StIdle: begin
        if (clear_pending_q) begin
          state_d     = StClear;
          clear_start = 1'b1;
          x_d         = '0;
          y_d         = '0;
        end else if (count_q != '0) begin
          state_d      = StRun;
          launch       = 1'b1;
          circ_start_d = 1'b1;
        end
      end
      StClear: begin
        if (y_q == YMax) begin
          y_d = '0;
          if (x_q == XMax) begin
            state_d = StIdle;
          end else begin
            x_d = x_q + 8'd1;
          end
        end else begin
          y_d = y_q + 7'd1;
        end
      end
      StRun: begin
        if (circ_done) begin
          state_d      = StWaitIdle;
          circ_start_d = 1'b0;
        end
      end
      StWaitIdle: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    clear_pending_d = clear_pending_q;
    if (clear_start) begin
      clear_pending_d = 1'b0;
    end else if (clear_req && (state_q != StClear)) begin
      clear_pending_d = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, launch})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    case (state_q)
      StClear: begin
        vga_x      = x_q;
        vga_y      = y_q;
        vga_colour = clr_colour_q;
        vga_plot   = 1'b1;
      end
      StRun: begin
        vga_x      = circ_vga_x;
        vga_y      = circ_vga_y;
        vga_colour = circ_vga_colour;
        vga_plot   = circ_vga_plot;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      clear_pending_q <= 1'b0;
      x_q             <= '0;
      y_q             <= '0;
      clr_colour_q    <= '0;
      circ_start_q    <= 1'b0;
      job_q           <= '0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      clear_pending_q <= clear_pending_d;
      x_q             <= x_d;
      y_q             <= y_d;
      circ_start_q    <= circ_start_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (launch) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        job_q    <= mem_q[rd_ptr_q];
      end
      if (clear_start) begin
        clr_colour_q <= clear_colour;
      end
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_colour, cmd_cx, cmd_cy, cmd_radius};
    end
  end

`ifdef DRAW_SCHED_STATS_EN
  logic [15:0] drawn_q;
  assign circles_drawn = drawn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drawn_q <= '0;
    end else if (done_accept && (drawn_q != 16'hFFFF)) begin
      drawn_q <= drawn_q + 16'd1;
    end
  end
`else
  logic unused_done_accept;
  assign unused_done_accept = done_accept;
`endif

endmodule
